// File: rtl/store_buffer_if.sv
// Core/memory-side signal bundle of the store buffer. The slave modport is the buffer
// itself; the master modport is the core plus data memory (or a bench standing in for them).
interface store_buffer_if;
    logic        memwriteM;
    logic        memreadM;
    logic [31:0] dataAdrM;
    logic [31:0] writedataM;
    logic [31:0] readDataM;
    logic        stallM;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_ready;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rd;
    logic        empty;
    logic [4:0]  dbg_count;

    // Handshakes: the core store is taken on a rising edge where memwriteM=1 and
    // stallM=0; a buffered store is retired on a rising edge where mem_we=1 and
    // mem_ready=1, and mem_we/mem_addr/mem_wd hold steady while mem_ready is low.
    modport master (
        output memwriteM, memreadM, dataAdrM, writedataM, mem_ready, mem_rd,
        input  readDataM, stallM, mem_we, mem_addr, mem_wd, mem_raddr, empty, dbg_count
    );
    modport slave (
        input  memwriteM, memreadM, dataAdrM, writedataM, mem_ready, mem_rd,
        output readDataM, stallM, mem_we, mem_addr, mem_wd, mem_raddr, empty, dbg_count
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between the core M stage and data memory with load-hit handling.
// Macro STORE_BUFFER_FORWARD_EN: defined = forward youngest hit, undefined = stall on hit.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic           clock,
    input logic           reset,
    store_buffer_if.slave sb
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_hit;
    logic w_stall;
    logic w_enq;
    logic w_deq;
`ifdef STORE_BUFFER_FORWARD_EN
    logic [31:0] w_fwd_data;
`endif

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // Walk entries oldest to youngest so the last match wins; the head entry stays
    // visible during the cycle it drains.
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((AW+1)'(k) < r_count) &&
                (r_addr[r_head + AW'(k)][31:2] == sb.dataAdrM[31:2])) begin
                w_hit = 1'b1;
            end
        end
    end

`ifdef STORE_BUFFER_FORWARD_EN
    always_comb begin
        w_fwd_data = 32'h0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((AW+1)'(k) < r_count) &&
                (r_addr[r_head + AW'(k)][31:2] == sb.dataAdrM[31:2])) begin
                w_fwd_data = r_data[r_head + AW'(k)];
            end
        end
    end

    assign w_stall      = sb.memwriteM && w_full;
    assign sb.readDataM = w_hit ? w_fwd_data : sb.mem_rd;
`else
    assign w_stall      = (sb.memwriteM && w_full) || (sb.memreadM && w_hit);
    assign sb.readDataM = sb.mem_rd;
`endif

    assign w_enq = sb.memwriteM && !w_stall;
    assign w_deq = !w_empty && sb.mem_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= 32'h0;
                r_data[i] <= 32'h0;
            end
        end else begin
            if (w_enq) begin
                r_addr[r_tail] <= sb.dataAdrM;
                r_data[r_tail] <= sb.writedataM;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign sb.stallM    = w_stall;
    assign sb.mem_we    = !w_empty;
    assign sb.mem_addr  = r_addr[r_head];
    assign sb.mem_wd    = r_data[r_head];
    assign sb.mem_raddr = sb.dataAdrM;
    assign sb.empty     = w_empty;
    assign sb.dbg_count = 5'(r_count);
endmodule
